step_sequencer: RTL and testbench

Front-panel timestep sequencer for the 10-bit processor, directly upstream of the output logic block. It synchronizes and debounces the raw step and peek pushbuttons, and advances the 2-bit processor timestep on each debounced step press or on a free-running auto tick. It produces TIME, DONE and Pkb for the output logic, plus a one-cycle Step enable for the controller and datapath.

---
 rtl/step_sequencer.sv | 119 +++++++++++
 tb/tb_step_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Front-panel timestep sequencer: synchronizes and debounces the step/peek keys and
// advances the 2-bit processor timestep on a debounced step press or an auto tick.
module step_sequencer #(
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned AUTO_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       KEYb_Step,
  input  logic       KEYb_Peek,
  input  logic       SW_Auto,
  input  logic       Clr,
  output logic [1:0] TIME,
  output logic       Step,
  output logic       DONE,
  output logic       Pkb
);

  localparam int unsigned NKEYS  = 2;
  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned AUTO_W = $clog2(AUTO_PERIOD);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  // key index 0 = step, 1 = peek
  logic [NKEYS-1:0]  key_meta;
  logic [NKEYS-1:0]  key_sync;
  logic [NKEYS-1:0]  key_stable;
  logic              auto_meta;
  logic              auto_sync;
  logic              step_prev;
  logic [AUTO_W-1:0] auto_cnt;
  logic              req_c;

  // Two-flop synchronizers; keys idle high, switch idles low
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta  <= '1;
      key_sync  <= '1;
      auto_meta <= 1'b0;
      auto_sync <= 1'b0;
    end else begin
      key_meta  <= {KEYb_Peek, KEYb_Step};
      key_sync  <= key_meta;
      auto_meta <= SW_Auto;
      auto_sync <= auto_meta;
    end
  end

  // Debouncers: stable follows the synced key only after DB_CYCLES consecutive differing samples
  for (genvar k = 0; k < NKEYS; k++) begin : g_db
    logic            stable_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        stable_q <= 1'b1;
        cnt_q    <= '0;
      end else if (key_sync[k] == stable_q) begin
        cnt_q    <= '0;
      end else if (cnt_q == DB_LAST) begin
        stable_q <= key_sync[k];
        cnt_q    <= '0;
      end else begin
        cnt_q    <= cnt_q + DB_W'(1);
      end
    end

    assign key_stable[k] = stable_q;
  end

  assign Pkb = key_stable[1];

  // Press edge detect and auto-step period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev <= 1'b1;
      auto_cnt  <= '0;
    end else begin
      step_prev <= key_stable[0];
      if (!auto_sync || auto_cnt == AUTO_LAST) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + AUTO_W'(1);
      end
    end
  end

  // In auto mode the step key is ignored, though step_prev keeps tracking it
  always_comb begin
    req_c = 1'b0;
    if (auto_sync) begin
      req_c = (auto_cnt == AUTO_LAST);
    end else begin
      req_c = step_prev & ~key_stable[0];
    end
  end

  // Timestep advance; Clr on a step restarts the instruction at timestep 0
  always_ff @(posedge clk) begin
    if (rst) begin
      TIME <= 2'd0;
      DONE <= 1'b0;
      Step <= 1'b0;
    end else begin
      Step <= req_c;
      if (req_c) begin
        if (Clr) begin
          TIME <= 2'd0;
          DONE <= 1'b1;
        end else begin
          TIME <= TIME + 2'd1;
          DONE <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: vector table, hand-written corner sequences
// and randomized stimulus compared every cycle against a behavioural model.
module tb_step_sequencer;

  localparam int DB = 4;
  localparam int AP = 8;

  logic       clk;
  logic       rst, k_step, k_peek, sw_auto, clr;
  logic [1:0] t_time;
  logic       t_step, t_done, t_pkb;

  int checks   = 0;
  int failures = 0;

  step_sequencer #(.DB_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clk       (clk),
    .rst       (rst),
    .KEYb_Step (k_step),
    .KEYb_Peek (k_peek),
    .SW_Auto   (sw_auto),
    .Clr       (clr),
    .TIME      (t_time),
    .Step      (t_step),
    .DONE      (t_done),
    .Pkb       (t_pkb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: inputs seen two edges late, a key level is accepted once the
  // last DB seen samples all disagree with the accepted level, auto steps fire on
  // every AP-th edge of a continuous run of seen auto mode.
  bit [1:0] sd, pd, ad;
  bit       win_s[$];
  bit       win_p[$];
  bit       m_ss, m_ps, m_fell, m_done, m_step;
  logic [1:0] m_time;
  int       m_run;

  function automatic bit all_differ(input bit q[$], input bit st);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit s_seen, p_seen, a_seen, req, old_ss;
    if (rst) begin
      sd = 2'b11; pd = 2'b11; ad = 2'b00;
      win_s.delete(); win_p.delete();
      repeat (DB) begin win_s.push_back(1'b1); win_p.push_back(1'b1); end
      m_ss = 1'b1; m_ps = 1'b1; m_fell = 1'b0; m_run = 0;
      m_time = 2'd0; m_done = 1'b0; m_step = 1'b0;
      return;
    end
    s_seen = sd[1]; sd = {sd[0], bit'(k_step)};
    p_seen = pd[1]; pd = {pd[0], bit'(k_peek)};
    a_seen = ad[1]; ad = {ad[0], bit'(sw_auto)};
    req   = a_seen ? ((m_run % AP) == AP - 1) : m_fell;
    m_run = a_seen ? m_run + 1 : 0;
    old_ss = m_ss;
    win_s.push_back(s_seen); if (win_s.size() > DB) void'(win_s.pop_front());
    win_p.push_back(p_seen); if (win_p.size() > DB) void'(win_p.pop_front());
    if (all_differ(win_s, m_ss)) m_ss = s_seen;
    if (all_differ(win_p, m_ps)) m_ps = p_seen;
    m_fell = old_ss && !m_ss;
    m_step = req;
    if (req) begin
      m_time = clr ? 2'd0 : 2'((int'(m_time) + 1) % 4);
      m_done = bit'(clr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", 32'({t_time, t_done, t_step, t_pkb}), 32'({m_time, m_done, m_step, m_ps}));
  endtask

  task automatic do_reset();
    rst = 1'b1; k_step = 1'b1; k_peek = 1'b1; sw_auto = 1'b0; clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Clean press held 20 cycles, then released for 10
  task automatic press(input logic c, input string nm, input int exp_t, input int exp_d);
    int lat, pulses;
    lat = -1; pulses = 0;
    k_step = 1'b0; clr = c;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (t_step === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
    check({nm, "_latency"}, 32'(lat), 32'd7);
    check({nm, "_pulses"}, 32'(pulses), 32'd1);
    check({nm, "_time"}, 32'(t_time), 32'(exp_t));
    check({nm, "_done"}, 32'(t_done), 32'(exp_d));
    k_step = 1'b1; clr = 1'b0;
    repeat (10) tick();
  endtask

  typedef struct {
    bit rst, ks, kp, sw, clr;
    int n;
    int t;
    bit d, s, p;
  } vec_t;

  function automatic vec_t mk(input int r, ks, kp, sw, c, n, t, d, s, p);
    vec_t v;
    v.rst = 1'(r); v.ks = 1'(ks); v.kp = 1'(kp); v.sw = 1'(sw); v.clr = 1'(c);
    v.n = n; v.t = t; v.d = 1'(d); v.s = 1'(s); v.p = 1'(p);
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   pulses, lat, n;
    int   pos[$];

    rst = 1'b1; k_step = 1'b1; k_peek = 1'b1; sw_auto = 1'b0; clr = 1'b0;

    //                 rst ks kp sw clr  n   T  D  S  P
    tbl.push_back(mk(1, 1, 1, 0, 0,  2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 20, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,  6, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 12, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 10, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1,  6, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1,  1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 10, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1,  5, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,  7, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 10, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,  5, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  5, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0,  9, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0,  1, 2, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0,  7, 2, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0,  1, 3, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 20, 3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,  7, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 10, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,  3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0,  3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,  3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0,  3, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; k_step = tbl[i].ks; k_peek = tbl[i].kp;
      sw_auto = tbl[i].sw; clr = tbl[i].clr;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d_time", i), 32'(t_time), 32'(tbl[i].t));
      check($sformatf("vec%0d_done", i), 32'(t_done), 32'(tbl[i].d));
      check($sformatf("vec%0d_step", i), 32'(t_step), 32'(tbl[i].s));
      check($sformatf("vec%0d_pkb", i), 32'(t_pkb), 32'(tbl[i].p));
    end

    // Bounce: short low glitches never step
    do_reset();
    pulses = 0;
    repeat (3) begin
      k_step = 1'b0;
      repeat (3) begin tick(); if (t_step === 1'b1) pulses++; end
      k_step = 1'b1;
      repeat (3) begin tick(); if (t_step === 1'b1) pulses++; end
    end
    check("bounce_pulses", 32'(pulses), 32'd0);

    // Press series: wrap through 3->0, then Clr ends the instruction
    press(1'b0, "p1", 1, 0);
    press(1'b0, "p2", 2, 0);
    press(1'b0, "p3", 3, 0);
    press(1'b0, "p4", 0, 0);
    press(1'b1, "p5", 0, 1);
    press(1'b0, "p6", 1, 0);

    // Auto mode for 40 cycles with a key press inside the window
    do_reset();
    sw_auto = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 41) sw_auto = 1'b0;
      if (i == 12) k_step = 1'b0;
      if (i == 22) k_step = 1'b1;
      tick();
      if (t_step === 1'b1) pos.push_back(i);
    end
    check("auto_count", 32'(pos.size()), 32'd5);
    for (int j = 0; j < 5; j++)
      check($sformatf("auto_step%0d_edge", j), 32'((pos.size() > j) ? pos[j] : -1), 32'(10 + 8 * j));
    check("auto_time", 32'(t_time), 32'd1);
    check("auto_done", 32'(t_done), 32'd0);

    // Reset while the step key is held
    do_reset();
    k_step = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("rst_time", 32'(t_time), 32'd0);
    check("rst_done", 32'(t_done), 32'd0);
    check("rst_step", 32'(t_step), 32'd0);
    check("rst_pkb", 32'(t_pkb), 32'd1);
    tick();
    rst = 1'b0;
    lat = -1; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (t_step === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
    check("rst_held_latency", 32'(lat), 32'd7);
    check("rst_held_pulses", 32'(pulses), 32'd1);
    k_step = 1'b1;
    repeat (10) tick();

    // Randomized segments checked against the model every cycle
    for (int seg = 0; seg < 250; seg++) begin
      rst    = ($urandom_range(0, 39) == 0);
      k_step = 1'($urandom_range(0, 1));
      k_peek = 1'($urandom_range(0, 1));
      clr    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) sw_auto = ~sw_auto;
      n = rst ? 1 : int'($urandom_range(1, 12));
      repeat (n) tick();
    end
    rst = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
